nova_bitstream_feeder: RTL

//  Upstream feeder for the nova_inter decoder wrapper. It consumes the decoder's OutputPacketType

---
 rtl/nova_bitstream_feeder_pkg.sv | 30 +++
 rtl/nova_bitstream_feeder_if.sv | 21 ++
 rtl/nova_bs_fifo.sv | 53 +++++
 rtl/nova_bitstream_feeder.sv | 111 +++++++++++
 4 files changed

// File: rtl/nova_bitstream_feeder_pkg.sv
// Shared types for the nova bitstream feeder: bitstream word/address types and the
// decoder-side request/response packets.
package nova_bitstream_feeder_pkg;

    localparam int BS_ADDR_W = 17;
    localparam int BS_DATA_W = 16;
    localparam int RAM_DATA_W = 32;

    typedef logic [BS_DATA_W-1:0]  BitstreamType;
    typedef logic [BS_ADDR_W-1:0]  BitstreamAddrType;
    typedef logic [RAM_DATA_W-1:0] RamDataType;

    // Response towards the decoder
    typedef struct packed {
        BitstreamType BitStream_buffer_input;
        RamDataType   ext_frame_RAM0_data;
        RamDataType   ext_frame_RAM1_data;
    } InputPacketType;

    // Request from the decoder; the read strobe is active-low
    typedef struct packed {
        logic             BitStream_ram_ren;
        BitstreamAddrType BitStream_ram_addr;
    } OutputPacketType;

    function automatic logic addr_is_oob(input BitstreamAddrType addr, input int unsigned words);
        return {15'd0, addr} >= words;
    endfunction

endpackage

// File: rtl/nova_bitstream_feeder_if.sv
// Decoder-facing handshake bundle: request packet with valid/stop, response packet with valid/stop.
interface nova_bitstream_feeder_if;
    import nova_bitstream_feeder_pkg::*;

    OutputPacketType reqPacket;
    logic            reqValid;
    logic            reqStop;
    InputPacketType  outPacket;
    logic            outValid;
    logic            outStop;

    modport master (
        output reqPacket, reqValid, outStop,
        input  reqStop, outPacket, outValid
    );

    modport slave (
        input  reqPacket, reqValid, outStop,
        output reqStop, outPacket, outValid
    );
endinterface

// File: rtl/nova_bs_fifo.sv
// Small synchronous FIFO with extended-pointer full/empty detection and an
// asynchronous (combinational) head read so the head is visible as soon as it is written.
module nova_bs_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_reg, rd_ptr_reg;
    logic             do_push, do_pop;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign count = wr_ptr_reg - rd_ptr_reg;

    // A push into a full FIFO is only legal when the head leaves in the same cycle
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign pop_data = mem_q[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end
endmodule

// File: rtl/nova_bitstream_feeder.sv
// Turns decoder bitstream read requests into fixed-latency RAM reads and returns the
// words in request order through a credit-protected response FIFO.
module nova_bitstream_feeder
    import nova_bitstream_feeder_pkg::*;
#(
    parameter int          READ_LAT   = 2,
    parameter int          FIFO_DEPTH = 4,
    parameter int unsigned BS_WORDS   = 131072
) (
    input  logic                    clk,
    input  logic                    reset,
    nova_bitstream_feeder_if.slave  bus,
    output logic                    mem_ren,
    output BitstreamAddrType        mem_addr,
    input  BitstreamType            mem_rdata,
    input  RamDataType              frame_RAM0_rdata,
    input  RamDataType              frame_RAM1_rdata,
    output logic                    err_oob
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [CW-1:0]       credits_reg;
    logic                request, accept, addr_oob;
    logic [READ_LAT:1]   pipe_vld_reg, pipe_vld_next;
    logic [READ_LAT:1]   pipe_oob_reg, pipe_oob_next;
    logic                push, pop;
    BitstreamType        push_data, fifo_head;
    logic                fifo_full, fifo_empty;
    logic [CW-1:0]       fifo_count;
    RamDataType          frame0_reg, frame1_reg;
    logic                err_oob_reg;

    // ren=1 packets are no-ops: never a request, never stalled
    assign request  = bus.reqValid && !bus.reqPacket.BitStream_ram_ren;
    assign bus.reqStop = !reset && request && (credits_reg == '0);
    assign accept   = !reset && request && (credits_reg != '0);
    assign addr_oob = addr_is_oob(bus.reqPacket.BitStream_ram_addr, BS_WORDS);

    assign mem_ren  = accept && !addr_oob;
    assign mem_addr = mem_ren ? bus.reqPacket.BitStream_ram_addr : '0;

    // Valid/OOB tags travel alongside the RAM so the tap lines up with mem_rdata
    assign pipe_vld_next[1] = accept;
    assign pipe_oob_next[1] = accept && addr_oob;
    generate
        for (genvar gi = 2; gi <= READ_LAT; gi++) begin : g_pipe
            assign pipe_vld_next[gi] = pipe_vld_reg[gi-1];
            assign pipe_oob_next[gi] = pipe_oob_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_vld_reg <= '0;
            pipe_oob_reg <= '0;
        end else begin
            pipe_vld_reg <= pipe_vld_next;
            pipe_oob_reg <= pipe_oob_next;
        end
    end

    assign push      = pipe_vld_reg[READ_LAT];
    assign push_data = pipe_oob_reg[READ_LAT] ? '0 : mem_rdata;
    assign pop       = bus.outValid && !bus.outStop;

    nova_bs_fifo #(
        .WIDTH (BS_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .srst      (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // A credit is held from accept until the response pops; it is usable again the next cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            credits_reg <= CW'(FIFO_DEPTH);
            err_oob_reg <= 1'b0;
            frame0_reg  <= '0;
            frame1_reg  <= '0;
        end else begin
            credits_reg <= credits_reg - CW'(accept) + CW'(pop);
            if (accept && addr_oob) begin
                err_oob_reg <= 1'b1;
            end
            frame0_reg <= frame_RAM0_rdata;
            frame1_reg <= frame_RAM1_rdata;
        end
    end

    assign bus.outValid = !fifo_empty;
    assign err_oob      = err_oob_reg;

    always_comb begin
        bus.outPacket = '0;
        bus.outPacket.BitStream_buffer_input = fifo_empty ? '0 : fifo_head;
        bus.outPacket.ext_frame_RAM0_data    = frame0_reg;
        bus.outPacket.ext_frame_RAM1_data    = frame1_reg;
    end

    assert property (@(posedge clk) disable iff (reset) !(push && fifo_full && !pop));
    assert property (@(posedge clk) disable iff (reset)
                     (int'(fifo_count) + int'(credits_reg)) <= FIFO_DEPTH);
endmodule
